muldiv: RTL and testbench

Iterative multiply/divide unit with the architectural HI/LO registers, sitting directly downstream of the register file in the execute stage. It consumes the two register-read operands for MULT, MULTU, DIV and DIVU and computes over multiple cycles with a start/busy/done handshake. MTHI/MTLO write HI and LO directly. HI and LO are always readable by the MFHI/MFLO datapath.

---
 rtl/muldiv.sv | 138 +++++++++++++
 tb/tb_muldiv.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/muldiv.sv
// Iterative multiply/divide unit holding the architectural HI/LO registers.
// Define MULDIV_DIV_EN to build the restoring divider; without it DIV/DIVU complete in one cycle with HI/LO untouched.
module muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wrdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH-1:0] opb;
    logic             is_div;
    logic             neg_res;

    // op[0]==0 marks the signed forms; magnitudes are unsigned so the most-negative value fits
    logic             rs_neg, rt_neg;
    logic [WIDTH-1:0] rs_mag, rt_mag;
    assign rs_neg = ~op[0] & rs_data[WIDTH-1];
    assign rt_neg = ~op[0] & rt_data[WIDTH-1];
    assign rs_mag = rs_neg ? -rs_data : rs_data;
    assign rt_mag = rt_neg ? -rt_data : rt_data;

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] prod, prod_fix;
    assign mul_sum  = acc_hi + (acc_lo[0] ? {1'b0, opb} : '0);
    assign prod     = {acc_hi[WIDTH-1:0], acc_lo};
    assign prod_fix = neg_res ? -prod : prod;

`ifdef MULDIV_DIV_EN
    logic             neg_rem;
    logic [WIDTH:0]   div_shift, div_trial;
    logic             div_ge;
    logic [WIDTH-1:0] rem_mag;
    assign div_shift = {acc_hi[WIDTH-1:0], acc_lo[WIDTH-1]};
    assign div_ge    = div_shift >= {1'b0, opb};
    assign div_trial = div_shift - {1'b0, opb};
    assign rem_mag   = acc_hi[WIDTH-1:0];
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            hi      <= '0;
            lo      <= '0;
            cnt     <= '0;
            acc_hi  <= '0;
            acc_lo  <= '0;
            opb     <= '0;
            is_div  <= 1'b0;
            neg_res <= 1'b0;
`ifdef MULDIV_DIV_EN
            neg_rem <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= ITER;
                        busy    <= 1'b1;
                        cnt     <= CW'(WIDTH);
                        is_div  <= op[1];
                        neg_res <= rs_neg ^ rt_neg;
                        acc_hi  <= '0;
                        acc_lo  <= op[1] ? rs_mag : rt_mag;
                        opb     <= op[1] ? rt_mag : rs_mag;
`ifdef MULDIV_DIV_EN
                        neg_rem <= rs_neg;
`endif
                    end else begin
                        if (mthi) hi <= wrdata;
                        if (mtlo) lo <= wrdata;
                    end
                end
                ITER: begin
`ifndef MULDIV_DIV_EN
                    if (is_div) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else
`endif
                    begin
                        cnt <= cnt - 1'b1;
                        if (cnt == CW'(1)) state <= FIX;
`ifdef MULDIV_DIV_EN
                        if (is_div) begin
                            acc_hi <= div_ge ? div_trial : div_shift;
                            acc_lo <= {acc_lo[WIDTH-2:0], div_ge};
                        end else
`endif
                        begin
                            acc_hi <= {1'b0, mul_sum[WIDTH:1]};
                            acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
                        end
                    end
                end
                FIX: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
`ifdef MULDIV_DIV_EN
                    if (is_div) begin
                        lo <= neg_res ? -acc_lo : acc_lo;
                        hi <= neg_rem ? -rem_mag : rem_mag;
                    end else
`endif
                    begin
                        hi <= prod_fix[2*WIDTH-1:WIDTH];
                        lo <= prod_fix[WIDTH-1:0];
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv.sv
// Self-checking bench for muldiv: directed vector table, hand sequences, and random ops against an arithmetic model.
module tb_muldiv;
    localparam int W = 32;
`ifdef MULDIV_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset, start, mthi, mtlo;
    logic [1:0]    op;
    logic [W-1:0]  rs_data, rt_data, wrdata;
    logic          busy, done;
    logic [W-1:0]  hi, lo;

    int cmp_cnt  = 0;
    int fail_cnt = 0;
    logic [W-1:0] cur_hi, cur_lo;

    muldiv #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .rs_data(rs_data), .rt_data(rt_data), .mthi(mthi), .mtlo(mtlo),
        .wrdata(wrdata), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a, b, eh, el;
    } vec_t;
    vec_t tbl[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic; divide by zero follows the restoring-algorithm rules.
    function automatic void ref_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] h, output logic [31:0] l);
        longint          sa, sb, sp, q, r;
        longint unsigned up;
        sa = $signed(a);
        sb = $signed(b);
        case (o)
            2'b00: begin sp = sa * sb; h = sp[63:32]; l = sp[31:0]; end
            2'b01: begin up = {32'b0, a} * {32'b0, b}; h = up[63:32]; l = up[31:0]; end
            2'b10: begin
                if (b == 0) begin
                    h = a;
                    l = (sa >= 0) ? 32'hFFFF_FFFF : 32'h0000_0001;
                end else begin
                    q = sa / sb; r = sa % sb;
                    h = r[31:0]; l = q[31:0];
                end
            end
            default: begin
                if (b == 0) begin h = a; l = 32'hFFFF_FFFF; end
                else begin h = a % b; l = a / b; end
            end
        endcase
    endfunction

    // Called at #1 after an edge with busy=0; returns at #1 after the done edge, so the next call is back-to-back.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el,
                          input bit disturb, input bit mv_with_start);
        int lat, n;
        bit busy_ok;
        if (o[1] && !DIV_EN) begin
            lat = 1; eh = cur_hi; el = cur_lo;
        end else begin
            lat = W + 1;
        end
        start = 1'b1; op = o; rs_data = a; rt_data = b;
        if (mv_with_start) begin mthi = 1'b1; mtlo = 1'b1; wrdata = 32'hDEAD_BEEF; end
        @(posedge clk); #1;
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        rs_data = $urandom; rt_data = $urandom;
        check("done_low_after_accept", 32'(done), 32'd0);
        n = 0; busy_ok = 1'b1;
        while (!done && n < 100) begin
            if (!busy) busy_ok = 1'b0;
            if (disturb && lat > 6 && n == 5) begin
                start = 1'b1; op = 2'b01; rs_data = $urandom; rt_data = $urandom;
                mthi = 1'b1; mtlo = 1'b1; wrdata = 32'hAAAA_5555;
            end
            @(posedge clk); #1;
            n++;
            start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        end
        check("latency", 32'(n), 32'(lat));
        check("busy_during_op", 32'(busy_ok), 32'd1);
        check("busy_low_at_done", 32'(busy), 32'd0);
        check("hi", hi, eh);
        check("lo", lo, el);
        cur_hi = eh; cur_lo = el;
    endtask

    task automatic move(input bit h, input bit l, input logic [31:0] v);
        mthi = h; mtlo = l; wrdata = v;
        @(posedge clk); #1;
        mthi = 1'b0; mtlo = 1'b0;
        if (h) cur_hi = v;
        if (l) cur_lo = v;
        check("move_hi", hi, cur_hi);
        check("move_lo", lo, cur_lo);
    endtask

    initial begin
        logic [1:0]  ro;
        logic [31:0] ra, rb, rh, rl;
        bit          saw_done;

        tbl[0] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        tbl[1] = '{2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
        tbl[2] = '{2'b01, 32'h0000_0002, 32'h0000_0003, 32'h0000_0000, 32'h0000_0006};
        tbl[3] = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        tbl[4] = '{2'b11, 32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF};
        tbl[5] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        tbl[6] = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'h0000_0001};
        tbl[7] = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        tbl[8] = '{2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};

        reset = 1'b1; start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        op = 2'b00; rs_data = '0; rt_data = '0; wrdata = '0;
        cur_hi = '0; cur_lo = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);
        reset = 1'b0;

        move(1'b1, 1'b1, 32'h5A5A_5A5A);
        move(1'b1, 1'b0, 32'h0000_1234);
        run_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b0);

        for (int i = 0; i < 9; i++)
            run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].eh, tbl[i].el, 1'b0, 1'b0);

        run_op(2'b01, 32'd5, 32'd7, 32'd0, 32'd35, 1'b1, 1'b0);
        run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd1, 1'b0, 1'b0);
        run_op(2'b11, 32'd9, 32'd4, 32'd1, 32'd2, 1'b0, 1'b1);

        for (int i = 0; i < 40; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 5)) : $urandom;
            ref_model(ro, ra, rb, rh, rl);
            run_op(ro, ra, rb, rh, rl, 1'b0, 1'b0);
        end

        @(posedge clk); #1;
        check("done_one_cycle", 32'(done), 32'd0);

        move(1'b1, 1'b1, 32'hC3C3_3C3C);
        start = 1'b1; op = 2'b00; rs_data = 32'h1234_5678; rt_data = 32'h9ABC_DEF0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_hi", hi, 32'd0);
        check("abort_lo", lo, 32'd0);
        saw_done = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) saw_done = 1'b1;
        end
        check("no_done_after_abort", 32'(saw_done), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", cmp_cnt, fail_cnt);
        $finish;
    end
endmodule
